// File: rtl/trojan_pkg.sv
// Shared types, payload-mode encodings and the operand-match helper for the
// sequentially triggered sum-corruption Trojan.
package trojan_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FIRE = 1'b1
    } state_e;

    localparam int PAY_REPLACE_B = 0;
    localparam int PAY_FLIP_LSB  = 1;
    localparam int PAY_XOR_MASK  = 2;

    // Operands are zero-extended to this width before comparison, so any WIDTH
    // up to MATCH_MAX_W shares one helper.
    localparam int MATCH_MAX_W = 256;

    function automatic logic is_match(input logic [MATCH_MAX_W-1:0] a,
                                      input logic [MATCH_MAX_W-1:0] b);
        return &(a ~^ b);
    endfunction

endpackage

// File: rtl/trojan_payload_mux.sv
// Combinational payload select: passes sum_in through, or substitutes the
// mode-specific corrupted value while sel is high.
module trojan_payload_mux
    import trojan_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter int               MODE     = PAY_REPLACE_B,
    parameter logic [WIDTH-1:0] XOR_MASK = WIDTH'(1)
) (
    input  logic [WIDTH-1:0] sum_in,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] payload;

    // NOTE: every signal written in always_comb gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        payload = b;
        case (MODE)
            PAY_FLIP_LSB: payload = sum_in ^ WIDTH'(1);
            PAY_XOR_MASK: payload = sum_in ^ XOR_MASK;
            default:      payload = b;
        endcase
        y = sel ? payload : sum_in;
    end

endmodule

// File: rtl/seq_trigger_trojan.sv
// Sequentially triggered Trojan: arms after TRIG_COUNT consecutive valid a == b
// cycles, then corrupts the sum for PAYLOAD_CYCLES valid cycles.
module seq_trigger_trojan
    import trojan_pkg::*;
#(
    parameter int               WIDTH          = 16,
    parameter int               TRIG_COUNT     = 4,
    parameter int               PAYLOAD_CYCLES = 8,
    parameter int               MODE           = PAY_REPLACE_B,
    parameter logic [WIDTH-1:0] XOR_MASK       = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] sum_in,
    output logic [WIDTH-1:0] sum_out,
    output logic             fire,
    output logic [7:0]       match_cnt
);

    localparam logic [7:0] TRIG_CNT_8 = 8'(TRIG_COUNT);
    localparam logic [7:0] PAY_LAST_8 = 8'(PAYLOAD_CYCLES - 1);

    state_e     state_q, state_d;
    logic [7:0] match_cnt_q, match_cnt_d;
    logic [7:0] pay_cnt_q, pay_cnt_d;
    logic       match;

    assign match = valid & is_match(MATCH_MAX_W'(a), MATCH_MAX_W'(b));

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            match_cnt_q <= '0;
            pay_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            match_cnt_q <= match_cnt_d;
            pay_cnt_q   <= pay_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        pay_cnt_d   = pay_cnt_q;
        case (state_q)
            IDLE: begin
                if (match) begin
                    if (match_cnt_q + 8'd1 >= TRIG_CNT_8) begin
                        state_d     = FIRE;
                        match_cnt_d = '0;
                        pay_cnt_d   = '0;
                    end else begin
                        match_cnt_d = match_cnt_q + 8'd1;
                    end
                end else if (valid) begin
                    match_cnt_d = '0;
                end
            end
            FIRE: begin
                // Matches are ignored here; only valid cycles consume the payload.
                match_cnt_d = '0;
                if (valid) begin
                    if (pay_cnt_q >= PAY_LAST_8) begin
                        state_d   = IDLE;
                        pay_cnt_d = '0;
                    end else begin
                        pay_cnt_d = pay_cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                match_cnt_d = '0;
                pay_cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        fire      = (state_q == FIRE);
        match_cnt = match_cnt_q;
    end

    trojan_payload_mux #(
        .WIDTH    (WIDTH),
        .MODE     (MODE),
        .XOR_MASK (XOR_MASK)
    ) u_payload_mux (
        .sum_in (sum_in),
        .b      (b),
        .sel    (fire),
        .y      (sum_out)
    );

endmodule

// File: tb/tb_seq_trigger_trojan.sv
// Self-checking bench: three Trojan instances (MODE 0/1/2) share stimulus and
// are compared every cycle against a behavioural trigger/payload model.
module tb_seq_trigger_trojan;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid;
    logic [W-1:0] a, b, sum_in;
    logic [W-1:0] sum_out0, sum_out1, sum_out2;
    logic         fire0, fire1, fire2;
    logic [7:0]   mcnt0, mcnt1, mcnt2;

    int checks = 0;
    int errors = 0;

    // Behavioural model: run length of consecutive matches, and payload cycles left.
    int m_run;
    int m_left;
    bit m_firing;

    always #5 clk = ~clk;

    seq_trigger_trojan #(.WIDTH(W), .TRIG_COUNT(4), .PAYLOAD_CYCLES(8), .MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .valid(valid), .a(a), .b(b), .sum_in(sum_in),
        .sum_out(sum_out0), .fire(fire0), .match_cnt(mcnt0));

    seq_trigger_trojan #(.WIDTH(W), .TRIG_COUNT(4), .PAYLOAD_CYCLES(8), .MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .valid(valid), .a(a), .b(b), .sum_in(sum_in),
        .sum_out(sum_out1), .fire(fire1), .match_cnt(mcnt1));

    seq_trigger_trojan #(.WIDTH(W), .TRIG_COUNT(4), .PAYLOAD_CYCLES(8), .MODE(2),
                         .XOR_MASK(16'h8001)) dut2 (
        .clk(clk), .rst_n(rst_n), .valid(valid), .a(a), .b(b), .sum_in(sum_in),
        .sum_out(sum_out2), .fire(fire2), .match_cnt(mcnt2));

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] exp_sum(input int mode, input logic [W-1:0] s,
                                             input logic [W-1:0] bb, input bit firing);
        if (!firing) return s;
        case (mode)
            1:       return {s[W-1:1], ~s[0]};
            2:       return s ^ 16'h8001;
            default: return bb;
        endcase
    endfunction

    task automatic model_reset();
        m_run    = 0;
        m_left   = 0;
        m_firing = 0;
    endtask

    task automatic model_update();
        if (!rst_n) begin
            model_reset();
        end else if (!m_firing) begin
            if (valid && a == b) begin
                m_run++;
                if (m_run == 4) begin
                    m_firing = 1;
                    m_left   = 8;
                    m_run    = 0;
                end
            end else if (valid) begin
                m_run = 0;
            end
        end else if (valid) begin
            m_left--;
            if (m_left == 0) m_firing = 0;
        end
    endtask

    task automatic compare_all(input string tag);
        check($sformatf("%s_fire0", tag), W'(fire0), W'(m_firing));
        check($sformatf("%s_fire1", tag), W'(fire1), W'(m_firing));
        check($sformatf("%s_fire2", tag), W'(fire2), W'(m_firing));
        check($sformatf("%s_mcnt0", tag), W'(mcnt0), W'(m_run));
        check($sformatf("%s_mcnt1", tag), W'(mcnt1), W'(m_run));
        check($sformatf("%s_mcnt2", tag), W'(mcnt2), W'(m_run));
        check($sformatf("%s_sum0", tag), sum_out0, exp_sum(0, sum_in, b, m_firing));
        check($sformatf("%s_sum1", tag), sum_out1, exp_sum(1, sum_in, b, m_firing));
        check($sformatf("%s_sum2", tag), sum_out2, exp_sum(2, sum_in, b, m_firing));
    endtask

    // Called at a falling edge: drive, check combinational view, advance one clock, return at next falling edge.
    task automatic step(input string tag, input logic r, input logic v,
                        input logic [W-1:0] aa, input logic [W-1:0] bb, input logic [W-1:0] s);
        rst_n  = r;
        valid  = v;
        a      = aa;
        b      = bb;
        sum_in = s;
        if (!r) model_reset();
        #1;
        compare_all(tag);
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] ra, rb, rs;
        rst_n  = 1'b0;
        valid  = 1'b0;
        a      = '0;
        b      = '0;
        sum_in = '0;
        model_reset();
        @(negedge clk);

        // 1: reset holds pass-through with random operands
        for (int i = 0; i < 4; i++) begin
            ra = W'($urandom); rb = W'($urandom); rs = W'($urandom);
            step("t1", 1'b0, 1'b1, ra, ra, rs);
            check("t1_pass", sum_out0, rs);
            check("t1_fire", W'(fire0), '0);
        end

        // 2: four matches arm, eight valid cycles replace the sum with b
        for (int i = 0; i < 4; i++) step("t2_trig", 1'b1, 1'b1, 16'h1234, 16'h1234, 16'h2468);
        check("t2_fire_on", W'(fire0), W'(1));
        for (int i = 0; i < 8; i++) begin
            step("t2_pay", 1'b1, 1'b1, 16'h1234, 16'h1234, 16'h2468);
            if (i < 7) check("t2_repl", sum_out0, 16'h1234);
        end
        check("t2_fire_off", W'(fire0), '0);
        check("t2_pass", sum_out0, 16'h2468);

        // 3: a broken sequence never fires
        step("t3_clr", 1'b1, 1'b1, 16'h0001, 16'h0002, 16'h0003);
        for (int i = 0; i < 3; i++) step("t3_m1", 1'b1, 1'b1, 16'h00AA, 16'h00AA, 16'h0154);
        check("t3_cnt3a", W'(mcnt0), W'(3));
        step("t3_brk", 1'b1, 1'b1, 16'h0001, 16'h0002, 16'h0003);
        check("t3_cnt0", W'(mcnt0), '0);
        for (int i = 0; i < 3; i++) step("t3_m2", 1'b1, 1'b1, 16'h00AA, 16'h00AA, 16'h0154);
        check("t3_cnt3b", W'(mcnt0), W'(3));
        check("t3_nofire", W'(fire0), '0);
        step("t3_clr2", 1'b1, 1'b1, 16'h0001, 16'h0002, 16'h0003);

        // 4: valid gaps neither break the trigger nor consume the payload; 5: modes 1 and 2
        for (int i = 0; i < 4; i++) begin
            step("t4_trig", 1'b1, 1'b1, 16'h5555, 16'h5555, 16'h1111);
            step("t4_gap", 1'b1, 1'b0, 16'h0001, 16'h0002, 16'h2222);
        end
        check("t4_fire_on", W'(fire0), W'(1));
        step("t5_m1", 1'b1, 1'b1, 16'h0007, 16'h0009, 16'h00FF);
        check("t5_mode1", sum_out1, 16'h00FE);
        step("t5_m2", 1'b1, 1'b1, 16'h0007, 16'h0009, 16'h0F0F);
        check("t5_mode2", sum_out2, 16'h8F0E);
        for (int i = 0; i < 6; i++) begin
            step("t4_gap2", 1'b1, 1'b0, W'($urandom), W'($urandom), W'($urandom));
            check("t4_hold", W'(fire0), W'(1));
            step("t4_pay", 1'b1, 1'b1, W'($urandom), W'($urandom), W'($urandom));
        end
        check("t4_fire_off", W'(fire0), '0);

        // 6: reset during the third payload cycle drops fire immediately
        for (int i = 0; i < 4; i++) step("t6_trig", 1'b1, 1'b1, 16'h0F0F, 16'h0F0F, 16'h0000);
        for (int i = 0; i < 2; i++) step("t6_pay", 1'b1, 1'b1, 16'h0F0F, 16'h0F0F, 16'h0000);
        check("t6_fire_pre", W'(fire0), W'(1));
        rs = W'($urandom);
        step("t6_rst", 1'b0, 1'b1, 16'h0F0F, 16'h0F0F, rs);
        for (int i = 0; i < 3; i++) step("t6_re3", 1'b1, 1'b1, 16'h0F0F, 16'h0F0F, 16'h0101);
        check("t6_nofire", W'(fire0), '0);
        step("t6_re4", 1'b1, 1'b1, 16'h0F0F, 16'h0F0F, 16'h0101);
        check("t6_refire", W'(fire0), W'(1));
        for (int i = 0; i < 8; i++) step("t6_drain", 1'b1, 1'b1, W'($urandom), W'($urandom), W'($urandom));

        // Random traffic biased towards matches, with occasional resets
        for (int i = 0; i < 500; i++) begin
            ra = W'($urandom_range(0, 3));
            rb = ($urandom_range(0, 9) < 7) ? ra : W'($urandom_range(0, 3));
            rs = W'($urandom);
            step("rnd", ($urandom_range(0, 149) != 0), ($urandom_range(0, 9) < 7), ra, rb, rs);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
